// File: rtl/alu_operand_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_operand_sequencer_if : FIFO read port + result handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface alu_operand_sequencer_if #(
  parameter int DATA_W = 8
) ();
  logic              fifo_empty;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [DATA_W-1:0] res_data;
  logic [3:0]        res_flags;
  logic              res_err;
  logic              res_valid;
  logic              res_ready;
  logic              busy;

  modport master (
    input  fifo_empty, rd_data, rd_valid, res_ready,
    output rd_req, res_data, res_flags, res_err, res_valid, busy
  );

  modport slave (
    output fifo_empty, rd_data, rd_valid, res_ready,
    input  rd_req, res_data, res_flags, res_err, res_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_operand_sequencer : pops {opcode, A, B} packets and presents ALU result
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   rst,
  alu_operand_sequencer_if.master bus
);

  localparam int              CNT_W    = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_OP, S_WAIT_OP, S_REQ_A, S_WAIT_A,
    S_REQ_B, S_WAIT_B, S_EXEC, S_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [3:0]        res_flags_q, res_flags_d;
  logic              res_err_q, res_err_d;
  logic              rd_req;
  logic              waiting;

  logic [DATA_W:0]   alu_wide, shr_wide;
  logic [DATA_W-1:0] alu_res;
  logic [2:0]        shamt;
  logic              alu_c, alu_v, alu_err;

  // Bit DATA_W of the widened result carries the carry/borrow/shifted-out bit.
  always_comb begin
    shamt    = b_q[2:0];
    alu_wide = '0;
    shr_wide = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_err  = 1'b0;
    case (op_q)
      3'd0: begin
        alu_wide = {1'b0, a_q} + {1'b0, b_q};
        alu_c    = alu_wide[DATA_W];
        alu_v    = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (alu_wide[DATA_W-1] != a_q[DATA_W-1]);
      end
      3'd1: begin
        alu_wide = {1'b0, a_q} - {1'b0, b_q};
        alu_c    = alu_wide[DATA_W];
        alu_v    = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (alu_wide[DATA_W-1] != a_q[DATA_W-1]);
      end
      3'd2: alu_wide = {1'b0, a_q & b_q};
      3'd3: alu_wide = {1'b0, a_q | b_q};
      3'd4: alu_wide = {1'b0, a_q ^ b_q};
      3'd5: begin
        alu_wide = {1'b0, a_q} << shamt;
        alu_c    = alu_wide[DATA_W];
      end
      3'd6: begin
        shr_wide = {a_q, 1'b0} >> shamt;
        alu_wide = {1'b0, shr_wide[DATA_W:1]};
        alu_c    = shr_wide[0];
      end
      default: alu_err = 1'b1;
    endcase
    alu_res = alu_wide[DATA_W-1:0];
  end

  assign waiting = (state_q == S_WAIT_OP) || (state_q == S_WAIT_A) || (state_q == S_WAIT_B);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_err_d   = res_err_q;
    rd_req      = 1'b0;
    case (state_q)
      S_IDLE:    if (!bus.fifo_empty) state_d = S_REQ_OP;
      S_REQ_OP, S_REQ_A, S_REQ_B: begin
        if (!bus.fifo_empty) begin
          rd_req = 1'b1;
          cnt_d  = '0;
          state_d = (state_q == S_REQ_OP) ? S_WAIT_OP :
                    (state_q == S_REQ_A)  ? S_WAIT_A  : S_WAIT_B;
        end
      end
      S_WAIT_OP: if (bus.rd_valid) begin op_d = bus.rd_data[2:0]; state_d = S_REQ_A; end
      S_WAIT_A:  if (bus.rd_valid) begin a_d  = bus.rd_data;      state_d = S_REQ_B; end
      S_WAIT_B:  if (bus.rd_valid) begin b_d  = bus.rd_data;      state_d = S_EXEC;  end
      S_EXEC: begin
        res_err_d   = alu_err;
        res_data_d  = alu_err ? '0 : alu_res;
        res_flags_d = alu_err ? 4'b0000 :
                      {alu_res[DATA_W-1], (alu_res == '0), alu_c, alu_v};
        state_d     = S_OUT;
      end
      S_OUT:     if (bus.res_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // A missing read response aborts the whole packet with an error result.
    if (waiting && !bus.rd_valid) begin
      if (cnt_q == CNT_LAST) begin
        state_d     = S_OUT;
        res_err_d   = 1'b1;
        res_data_d  = '0;
        res_flags_d = 4'b0000;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus.rd_req    = rd_req;
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_valid = (state_q == S_OUT);
  assign bus.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_operand_sequencer : FIFO/sink model with arithmetic reference
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_operand_sequencer;
  localparam int DATA_W     = 8;
  localparam int RD_TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_sequencer_if #(.DATA_W(DATA_W)) bus ();

  alu_operand_sequencer #(.DATA_W(DATA_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clock (clk),
    .rst   (rst),
    .bus   (bus.master)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] flags;
    logic       err;
  } res_t;

  res_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         req_cyc[$];
  int checks = 0, errors = 0, cyc = 0, req_count = 0, xfers = 0;
  int special_req = -1, special_delay = 0, fixed_delay = 1;
  bit rand_delay = 0, rand_ready = 0;
  bit resp_pending = 0;
  int resp_at = 0;
  logic [7:0] resp_data = '0;
  int ready_hold = 0, hold_cycles = 0, last_hold = 0;
  int drop_cyc = 0, valid_start = 0;
  bit prev_valid = 0, chk_busy_next = 0, busy_after = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference ALU from the arithmetic definitions, signed view via plain ints.
  function automatic res_t ref_alu(input int op, input int a, input int b);
    res_t t;
    int r, c, v, sa, sb, s, sh;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    sh = b % 8;
    c = 0; v = 0; r = 0;
    case (op % 8)
      0: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127 || s < -128); end
      1: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127 || s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a << sh; c = (sh == 0) ? 0 : (a >> (8 - sh)) & 1; end
      6: begin r = a >> sh; c = (sh == 0) ? 0 : (a >> (sh - 1)) & 1; end
      default: begin t.data = 8'h00; t.flags = 4'h0; t.err = 1'b1; return t; end
    endcase
    r = r & 255;
    t.data  = r[7:0];
    t.flags = {r >= 128, r == 0, c != 0, v != 0};
    t.err   = 1'b0;
    return t;
  endfunction

  task automatic add_exp(input logic [7:0] d, input logic [3:0] f, input logic e);
    res_t t;
    t.data = d; t.flags = f; t.err = e;
    exp_q.push_back(t);
  endtask

  task automatic push_words(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    fifo_q.push_back(op); fifo_q.push_back(a); fifo_q.push_back(b);
  endtask

  task automatic push_dir(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input logic [3:0] f, input logic e);
    push_words(op, a, b);
    add_exp(d, f, e);
  endtask

  task automatic push_pkt(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    push_words(op, a, b);
    exp_q.push_back(ref_alu(int'(op), int'(a), int'(b)));
  endtask

  function automatic int req_at(input int i);
    return (i < req_cyc.size()) ? req_cyc[i] : -1000;
  endfunction

  // One clock: drive inputs at negedge, observe 1 time unit later.
  task automatic step();
    logic [7:0] w;
    int d;
    res_t e;
    @(negedge clk);
    cyc++;
    bus.fifo_empty = (fifo_q.size() == 0);
    if (resp_pending && cyc == resp_at) begin
      bus.rd_valid = 1'b1; bus.rd_data = resp_data; resp_pending = 0;
    end else begin
      bus.rd_valid = 1'b0; bus.rd_data = 8'($urandom);
    end
    bus.res_ready = (ready_hold == 0);
    #1;
    if (busy_after) begin
      check("busy_after_xfer", bus.busy, 0);
      check("valid_after_xfer", bus.res_valid, 0);
      busy_after = 0;
    end
    if (fifo_q.size() == 0) check("req_when_empty", bus.rd_req, 0);
    if (bus.rd_req && !rst && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      req_count++;
      req_cyc.push_back(cyc);
      d = rand_delay ? int'($urandom_range(1, 4)) : fixed_delay;
      if (req_count == special_req) d = special_delay;
      if (d < 0) drop_cyc = cyc;
      else begin resp_pending = 1; resp_at = cyc + d; resp_data = w; end
    end
    if (bus.res_valid && !rst) begin
      if (!prev_valid) valid_start = cyc;
      if (exp_q.size() == 0) check("spurious_valid", bus.res_valid, 0);
      else begin
        e = exp_q[0];
        check("res_data", bus.res_data, e.data);
        check("res_flags", bus.res_flags, e.flags);
        check("res_err", bus.res_err, e.err);
        if (bus.res_ready) begin
          void'(exp_q.pop_front());
          xfers++;
          last_hold = hold_cycles; hold_cycles = 0;
          if (chk_busy_next) busy_after = 1;
          ready_hold = rand_ready ? int'($urandom_range(0, 3)) : 0;
        end else begin
          hold_cycles++;
          if (ready_hold > 0) ready_hold--;
        end
      end
    end
    prev_valid = bus.res_valid;
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (xfers < n && k < budget) begin step(); k++; end
    check("xfer_budget", xfers, n);
  endtask

  task automatic check_reset_state();
    check("rst_rd_req", bus.rd_req, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_flags", bus.res_flags, 0);
    check("rst_res_err", bus.res_err, 0);
  endtask

  initial begin
    int r0, k;
    bus.fifo_empty = 1'b1; bus.rd_valid = 1'b0; bus.rd_data = '0; bus.res_ready = 1'b1;
    rst = 1'b1;
    step(); step();
    check_reset_state();
    rst = 1'b0;

    // ADD overflow with exact pipeline timing; second packet queued behind it
    req_cyc.delete();
    push_dir(8'h00, 8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0);
    push_dir(8'h01, 8'h00, 8'h01, 8'hFF, 4'b1010, 1'b0);
    run_until(1, 60);
    check("lat_req_a", req_at(1) - req_at(0), 2);
    check("lat_req_b", req_at(2) - req_at(0), 4);
    check("lat_valid", valid_start - req_at(0), 7);
    run_until(2, 60);
    check("lat_next_req", req_at(3) - req_at(0), 9);

    push_dir(8'h01, 8'h05, 8'h05, 8'h00, 4'b0100, 1'b0);
    push_dir(8'h05, 8'h81, 8'h01, 8'h02, 4'b0010, 1'b0);
    push_dir(8'h06, 8'h81, 8'h01, 8'h40, 4'b0010, 1'b0);
    push_dir(8'h05, 8'h81, 8'h00, 8'h81, 4'b1000, 1'b0);
    run_until(6, 200);

    // Illegal opcode under 5 cycles of backpressure
    ready_hold = 5; chk_busy_next = 1;
    push_dir(8'h07, 8'h12, 8'h34, 8'h00, 4'b0000, 1'b1);
    run_until(7, 60);
    check("hold_cycles", last_hold, 5);
    step();
    chk_busy_next = 0;

    // FIFO runs dry after the opcode: stall without error
    r0 = req_count;
    fifo_q.push_back(8'h00);
    add_exp(8'h30, 4'b0000, 1'b0);
    repeat (12) step();
    check("stall_reqs", req_count - r0, 1);
    check("stall_busy", bus.busy, 1);
    fifo_q.push_back(8'h10); fifo_q.push_back(8'h20);
    run_until(8, 60);

    // Operand B response never arrives
    special_req = req_count + 3; special_delay = -1;
    push_dir(8'h00, 8'h01, 8'h02, 8'h00, 4'b0000, 1'b1);
    run_until(9, 80);
    check("timeout_lat", valid_start - drop_cyc, RD_TIMEOUT + 1);

    // Response in the last allowed wait cycle is still accepted
    special_req = req_count + 2; special_delay = RD_TIMEOUT;
    push_dir(8'h00, 8'h40, 8'h40, 8'h80, 4'b1001, 1'b0);
    run_until(10, 80);
    special_req = -1;

    // Reset while waiting for operand A
    r0 = req_count; fixed_delay = 3;
    push_words(8'h00, 8'h11, 8'h22);
    k = 0;
    while (req_count < r0 + 2 && k < 40) begin step(); k++; end
    check("reach_wait_a", req_count - r0, 2);
    resp_pending = 0; fifo_q.delete();
    rst = 1'b1;
    step(); step();
    check_reset_state();
    rst = 1'b0; fixed_delay = 1;
    push_dir(8'h02, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0);
    run_until(11, 60);

    // Randomized packets, response delays and backpressure
    rand_delay = 1; rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      push_pkt(8'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end
    run_until(51, 4000);
    check("exp_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
